// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the CPU and video scanout.
// Video has priority, bounded by a burst limit; each access is IDLE -> ACCESS -> RESP.
module mem_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned VID_BURST = 4,
    parameter int unsigned WR_EN_BIT = 13
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_data,
    input  logic              i_cpu_read,
    input  logic              i_cpu_write,
    output logic [DATA_W-1:0] o_cpu_data,
    output logic              o_cpu_ready,
    input  logic [ADDR_W-1:0] i_vid_addr,
    input  logic              i_vid_read,
    output logic [DATA_W-1:0] o_vid_data,
    output logic              o_vid_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_rom_wr_err
);

    localparam int unsigned CntW = $clog2(VID_BURST + 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q;
    logic              owner_cpu_q;
    logic              rd_q;
    logic              drop_q;
    logic [CntW-1:0]   burst_q;
    logic [CntW-1:0]   burst_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              mem_re_q;
    logic [DATA_W-1:0] cpu_data_q;
    logic [DATA_W-1:0] vid_data_q;
    logic              cpu_ready_q;
    logic              vid_ready_q;
    logic              rom_err_q;

    logic cpu_any;
    logic cpu_req;
    logic vid_req;
    logic cpu_first;
    logic vid_pick;
    logic grant_vid;
    logic grant_cpu;

    // A requester in its ready cycle is masked from being granted, but a masked
    // video request still holds priority: that cycle then grants nobody.
    always_comb begin
        cpu_any   = i_cpu_read | i_cpu_write;
        cpu_req   = cpu_any & ~cpu_ready_q;
        vid_req   = i_vid_read & ~vid_ready_q;
        cpu_first = cpu_req && (burst_q == CntW'(VID_BURST));
        vid_pick  = i_vid_read && !cpu_first;
        grant_vid = vid_pick && vid_req;
        grant_cpu = !vid_pick && cpu_req;

        burst_d = burst_q;
        if (grant_cpu || !cpu_any) begin
            burst_d = '0;
        end else if (grant_vid && (burst_q < CntW'(VID_BURST))) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            owner_cpu_q <= 1'b0;
            rd_q        <= 1'b0;
            drop_q      <= 1'b0;
            burst_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            cpu_data_q  <= '0;
            vid_data_q  <= '0;
            cpu_ready_q <= 1'b0;
            vid_ready_q <= 1'b0;
            rom_err_q   <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            vid_ready_q <= 1'b0;
            rom_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    burst_q <= burst_d;
                    if (grant_vid) begin
                        owner_cpu_q <= 1'b0;
                        rd_q        <= 1'b1;
                        drop_q      <= 1'b0;
                        mem_addr_q  <= i_vid_addr;
                        mem_re_q    <= 1'b1;
                        state_q     <= StAccess;
                    end else if (grant_cpu) begin
                        owner_cpu_q <= 1'b1;
                        mem_addr_q  <= i_cpu_addr;
                        state_q     <= StAccess;
                        if (i_cpu_write) begin
                            // Writes below the enable bit hit ROM: run the cycle, suppress the strobe.
                            rd_q        <= 1'b0;
                            mem_wdata_q <= i_cpu_data;
                            mem_we_q    <= i_cpu_addr[WR_EN_BIT];
                            drop_q      <= ~i_cpu_addr[WR_EN_BIT];
                        end else begin
                            rd_q     <= 1'b1;
                            mem_re_q <= 1'b1;
                            drop_q   <= 1'b0;
                        end
                    end
                end
                StAccess: begin
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= StResp;
                end
                StResp: begin
                    if (owner_cpu_q) begin
                        cpu_ready_q <= 1'b1;
                        rom_err_q   <= drop_q;
                        if (rd_q) begin
                            cpu_data_q <= i_mem_rdata;
                        end
                    end else begin
                        vid_ready_q <= 1'b1;
                        vid_data_q  <= i_mem_rdata;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cpu_data   = cpu_data_q;
    assign o_cpu_ready  = cpu_ready_q;
    assign o_vid_data   = vid_data_q;
    assign o_vid_ready  = vid_ready_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_re     = mem_re_q;
    assign o_rom_wr_err = rom_err_q;

endmodule
